// File: rtl/systolic_feeder.sv
// Operand skew feeder for an N x N bit-level systolic multiplier array.
// Bit r of A and bit c of B are launched so they meet at cell (r,c) on step r+c.
//   state   | meaning
//   IDLE    | waiting for an operand pair, in_ready high
//   FEED    | step counter walks 0..N-1, one operand bit per row/column
//   DRAIN   | zero feed while the last partial products ripple through
//   DONE    | single-cycle done pulse, then back to IDLE
module systolic_feeder #(
    parameter int N            = 4,
    parameter int DRAIN_CYCLES = 2*N-1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    output logic [N-1:0] a_row,
    output logic [N-1:0] b_col,
    output logic         busy,
    output logic         done
);

    localparam int MAXC = (N > DRAIN_CYCLES) ? N : DRAIN_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] FEED_LAST  = CW'(N-1);
    localparam logic [CW-1:0] DRAIN_LAST = (DRAIN_CYCLES > 0) ? CW'(DRAIN_CYCLES-1) : '0;
    localparam logic [N-1:0]  ONE        = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   a_row_q, a_row_d;
    logic [N-1:0]   b_col_q, b_col_d;
    logic [N-1:0]   step_sel_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_row_q <= '0;
            b_col_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            a_row_q <= a_row_d;
            b_col_q <= b_col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = S_FEED;
                end
            end
            S_FEED: begin
                if (cnt_q == FEED_LAST) begin
                    cnt_d   = '0;
                    state_d = (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are precomputed from next state so each step lands in the cycle after its edge.
    always_comb begin
        step_sel_d = ONE << cnt_d;
        a_row_d    = '0;
        b_col_d    = '0;
        if (state_d == S_FEED) begin
            a_row_d = a_d & step_sel_d;
            b_col_d = b_d & step_sel_d;
        end
    end

    assign a_row    = a_row_q;
    assign b_col    = b_col_q;
    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: vector table, hand sequences, random run against a
// cycles-since-accept reference model, and a bit-level PE array fed by the DUT.
module tb_systolic_feeder;

    localparam int N   = 4;
    localparam int D   = 2*N-1;
    localparam int LAT = N + D + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a_in, b_in, a_row, b_col;
    logic         busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_seen = 0;
    int accept_cycles[$];

    int           m_phase = 0;
    logic [N-1:0] m_a = '0, m_b = '0;

    always #5 clk = ~clk;

    systolic_feeder #(.N(N), .DRAIN_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .a_row(a_row), .b_col(b_col),
        .busy(busy), .done(done)
    );

    // Bit-level PE array: a bits travel right, b bits travel down, each cell adds a&b << (r+c).
    logic [N-1:0] a_pe [N];
    logic [N-1:0] b_pe [N];
    int           pe_sum;

    function automatic int pe_products();
        int   s;
        logic ai, bi;
        s = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                ai = (c == 0) ? a_row[r] : a_pe[r][c-1];
                bi = (r == 0) ? b_col[c] : b_pe[r-1][c];
                if (ai && bi) s += (1 << (r + c));
            end
        return s;
    endfunction

    always @(posedge clk) begin
        if (in_valid && in_ready && !rst) begin
            pe_sum <= 0;
            for (int r = 0; r < N; r++) begin
                a_pe[r] <= '0;
                b_pe[r] <= '0;
            end
        end else begin
            pe_sum <= pe_sum + pe_products();
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++) begin
                    a_pe[r][c] <= (c == 0) ? a_row[r] : a_pe[r][c-1];
                    b_pe[r][c] <= (r == 0) ? b_col[c] : b_pe[r-1][c];
                end
        end
    end

    function automatic logic [31:0] expected();
        logic [N-1:0] ea, eb, one;
        one = 1;
        ea  = '0;
        eb  = '0;
        if (m_phase >= 1 && m_phase <= N) begin
            ea = m_a & (one << (m_phase - 1));
            eb = m_b & (one << (m_phase - 1));
        end
        return 32'({ea, eb, m_phase != 0, m_phase == LAT, m_phase == 0});
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        logic dut_acc;
        dut_acc = in_valid && in_ready && !rst;
        @(posedge clk);
        cyc++;
        if (dut_acc) accept_cycles.push_back(cyc);
        if (rst) begin
            m_phase = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase = 1;
                m_a     = a_in;
                m_b     = b_in;
            end
        end else if (m_phase == LAT) begin
            m_phase = 0;
        end else begin
            m_phase++;
        end
        #1;
        if (done) done_seen++;
        check("model", 32'({a_row, b_col, busy, done, in_ready}), expected());
    endtask

    typedef struct {
        logic         rst, iv;
        logic [N-1:0] a, b, ea, eb;
        logic         ebusy, edone, erdy;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic r, input logic iv, input logic [N-1:0] a,
                                input logic [N-1:0] b, input logic [N-1:0] ea,
                                input logic [N-1:0] eb, input logic bs,
                                input logic dn, input logic rd);
        vec_t v;
        v.rst = r; v.iv = iv; v.a = a; v.b = b; v.ea = ea; v.eb = eb;
        v.ebusy = bs; v.edone = dn; v.erdy = rd;
        tbl.push_back(v);
    endfunction

    initial begin
        int d0;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;

        add(1, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 1);
        add(1, 1, 4'hf, 4'hf, 4'b0000, 4'b0000, 0, 0, 1);
        add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 1);
        add(0, 1, 4'b1011, 4'b0110, 4'b0001, 4'b0000, 1, 0, 0);
        add(0, 0, 4'b0101, 4'b1001, 4'b0010, 4'b0010, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0100, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 4'b1000, 4'b0000, 1, 0, 0);
        for (int i = 0; i < D; i++) add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 1, 0);
        add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 1);
        add(0, 1, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 0, 0);
        for (int i = 0; i < LAT-2; i++) add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 0, 0);
        add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 1, 1, 0);
        add(0, 0, 4'h0, 4'h0, 4'b0000, 4'b0000, 0, 0, 1);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; in_valid = tbl[i].iv; a_in = tbl[i].a; b_in = tbl[i].b;
            tick();
            check($sformatf("vec%0d", i), 32'({a_row, b_col, busy, done, in_ready}),
                  32'({tbl[i].ea, tbl[i].eb, tbl[i].ebusy, tbl[i].edone, tbl[i].erdy}));
        end

        // Full-ones operands through the PE array must multiply to 15*15.
        rst = 1'b0; in_valid = 1'b1; a_in = 4'hf; b_in = 4'hf;
        tick();
        in_valid = 1'b0;
        repeat (LAT-1) tick();
        check("pe_done", 32'(done), 32'd1);
        check("pe_sum", pe_sum, 32'd225);
        tick();

        // Reset while FEED is showing step 2.
        in_valid = 1'b1; a_in = 4'b1111; b_in = 4'b1111;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_abort", 32'({a_row, b_col, busy, in_ready}), 32'({4'b0000, 4'b0000, 1'b0, 1'b1}));
        d0 = done_seen;
        repeat (LAT+2) tick();
        check("rst_no_done", done_seen - d0, 32'd0);

        // in_valid held high with operands changing every cycle.
        accept_cycles.delete();
        in_valid = 1'b1;
        for (int i = 0; i < 45; i++) begin
            a_in = N'($urandom);
            b_in = N'($urandom);
            tick();
        end
        in_valid = 1'b0;
        check("accept_count", accept_cycles.size(), 32'd4);
        for (int i = 1; i < accept_cycles.size(); i++)
            check("issue_gap", accept_cycles[i] - accept_cycles[i-1], LAT + 1);
        repeat (LAT+1) tick();

        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 40) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            a_in     = N'($urandom);
            b_in     = N'($urandom);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0;
        repeat (LAT+1) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the operand width and the array dimension (N rows x N columns).
REQ-002 The block SHALL have parameter DRAIN_CYCLES, default 2*N-1, giving the number of zero-feed cycles after the last feed step.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an operand pair is presented on a_in/b_in.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand pair this cycle.
REQ-007 The block SHALL have port a_in, input, N bits: multiplicand A.
REQ-008 The block SHALL have port b_in, input, N bits: multiplier B.
REQ-009 The block SHALL have port a_row, output, N bits: bit r drives the a-input of array row r at column 0.
REQ-010 The block SHALL have port b_col, output, N bits: bit c drives the b-input of array column c at row 0.
REQ-011 The block SHALL have port busy, output, 1 bit: an operation is in progress (FEED, DRAIN or DONE).
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that the array's final sum is valid.

Function
REQ-013 The block SHALL implement states IDLE, FEED, DRAIN and DONE, with a step counter of width clog2(max(N, DRAIN_CYCLES)).
REQ-014 in_ready SHALL equal 1 only in IDLE; an accept is in_valid=1 and in_ready=1 at a rising edge.
REQ-015 On accept, the block SHALL register a_in/b_in into internal A/B, clear the step counter and enter FEED.
REQ-016 in_valid while not in IDLE SHALL be ignored; the operands SHALL NOT be captured and the state SHALL NOT be disturbed.
REQ-017 In FEED at step s (0..N-1), registered outputs SHALL be a_row[r] = A[r] when r==s, else 0, and b_col[c] = B[c] when c==s, else 0.
REQ-018 This skew SHALL make a_r and b_c coincide at cell (r,c) at step r+c.
REQ-019 Feed step s SHALL appear on a_row/b_col during the (s+1)-th cycle after the accept edge.
REQ-020 FEED SHALL last exactly N cycles, then the block SHALL enter DRAIN with the counter cleared.
REQ-021 DRAIN SHALL last exactly DRAIN_CYCLES cycles with a_row=0 and b_col=0.
REQ-022 With DRAIN_CYCLES=0, the block SHALL go directly from FEED to DONE.
REQ-023 DONE SHALL last exactly one cycle, with done=1, a_row=0, b_col=0 and in_ready=0, then go to IDLE.
REQ-024 Accept-to-done latency SHALL be N+DRAIN_CYCLES+1 cycles (12 at defaults), with done in that cycle.
REQ-025 Back-to-back operations SHALL be separated by at least one IDLE cycle; the minimum issue interval is N+DRAIN_CYCLES+2 cycles.
REQ-026 busy SHALL equal 1 in FEED, DRAIN and DONE, and 0 in IDLE.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.
REQ-028 The step counter SHALL wrap to 0 only on a state transition and SHALL never exceed its terminal count.

Reset
REQ-029 While rst=1 at a rising edge, the block SHALL enter IDLE and clear A, B and the counter.
REQ-030 After such a reset edge, outputs SHALL be a_row=0, b_col=0, busy=0, done=0 and in_ready=1.
REQ-031 A reset during FEED, DRAIN or DONE SHALL abort the operation, with no done pulse and outputs zeroed on the next cycle.
REQ-032 When rst=1 and in_valid=1 at the same edge, reset SHALL win and no accept SHALL occur.

Verification
REQ-033 The bench SHALL cover skew for A=4'b1011, B=4'b0110: a_row sequence 0001, 0010, 0000, 1000 and b_col sequence 0000, 0010, 0100, 0000, then 7 zero cycles, then done=1 at accept+12.
REQ-034 The bench SHALL cover A=4'b1111, B=4'b1111 fed into a 4x4 pe_cell array: the array sum output at the done cycle equals 8'd225.
REQ-035 The bench SHALL cover in_valid held high continuously: accepts occur only in IDLE, spaced 13 cycles apart, and operands changed mid-operation are not captured.
REQ-036 The bench SHALL cover rst=1 at FEED step 2: the next cycle shows a_row=0, b_col=0, busy=0 and in_ready=1, and no done pulse occurs.
REQ-037 The bench SHALL cover A=0, B=0: a_row and b_col stay 0 throughout, and done still pulses at accept+12.
REQ-038 The bench SHALL cover a rst=1 and in_valid=1 collision at the same edge: no accept occurs and the block stays in IDLE.
